// File: rtl/cnn_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnn_pkg : shared constants and FSM encoding for the CNN frame streamer  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package cnn_pkg;

    localparam int PIXELS_PER_IMAGE = 784;
    localparam int CLASS_W          = 4;

    typedef logic [CLASS_W-1:0] class_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        GAP      = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_frame_streamer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnn_frame_streamer_if : frame/label memory and CNN port bundle          |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface cnn_frame_streamer_if
    import cnn_pkg::*;
#(
    parameter int PIX_ADDR_W = 20,
    parameter int IMG_W      = 10
);
    logic [PIX_ADDR_W-1:0] pix_addr;
    logic                  pix_rd;
    logic [7:0]            pix_rdata;
    logic [IMG_W-1:0]      lbl_addr;
    class_t                lbl_rdata;
    logic [7:0]            data_in;
    logic                  valid_in;
    class_t                decision;
    logic                  valid_out;
    logic                  cnn_busy;

    modport master (
        output pix_addr, pix_rd, lbl_addr, data_in, valid_in,
        input  pix_rdata, lbl_rdata, decision, valid_out, cnn_busy
    );

    modport slave (
        input  pix_addr, pix_rd, lbl_addr, data_in, valid_in,
        output pix_rdata, lbl_rdata, decision, valid_out, cnn_busy
    );
endinterface
`default_nettype wire

// File: rtl/cnn_result_scoreboard.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnn_result_scoreboard : label register, decision compare, timeout watch |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cnn_result_scoreboard
    import cnn_pkg::*;
#(
    parameter int IMG_W          = 10,
    parameter int RESULT_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load_label,
    input  class_t           i_label,
    input  logic             i_wait_active,
    input  logic             i_valid_out,
    input  class_t           i_decision,
    output logic             o_resolve,
    output logic [IMG_W:0]   o_correct_count,
    output logic             o_timeout_err
);
    localparam int TMR_W = $clog2(RESULT_TIMEOUT + 1);

    class_t             r_label_q;
    logic [TMR_W-1:0]   r_timer;
    logic [IMG_W:0]     r_correct_count;
    logic               r_timeout_err;
    logic               w_expired;
    logic               w_hit;

    // Timer is zero in the first WAIT_RES cycle, which carries the last pixel beat.
    assign w_expired       = (r_timer == TMR_W'(RESULT_TIMEOUT - 1));
    assign w_hit           = i_wait_active & i_valid_out;
    assign o_resolve       = i_wait_active & (i_valid_out | w_expired);
    assign o_correct_count = r_correct_count;
    assign o_timeout_err   = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_label_q       <= '0;
            r_timer         <= '0;
            r_correct_count <= '0;
            r_timeout_err   <= 1'b0;
        end else begin
            if (i_load_label) begin
                r_label_q <= i_label;
            end

            if (!i_wait_active || o_resolve) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (i_clear) begin
                r_correct_count <= '0;
                r_timeout_err   <= 1'b0;
            end else begin
                if (w_hit && (i_decision == r_label_q)) begin
                    r_correct_count <= r_correct_count + 1'b1;
                end
                if (i_wait_active && !i_valid_out && w_expired) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cnn_frame_streamer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cnn_frame_streamer : multi-image pixel source and accuracy scoreboard   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module cnn_frame_streamer
    import cnn_pkg::*;
#(
    parameter int MAX_IMAGES     = 1000,
    parameter int PIX_ADDR_W     = 20,
    parameter int IMG_W          = 10,
    parameter int CYC_W          = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int RESULT_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IMG_W-1:0]      num_images,
    cnn_frame_streamer_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic [IMG_W:0]        correct_count,
    output logic [IMG_W-1:0]      image_index,
    output logic [CYC_W-1:0]      total_cycles,
    output logic                  timeout_err
);
    localparam int                PIX_IDX_W = $clog2(PIXELS_PER_IMAGE);
    localparam int                GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IMG_W-1:0]  C_MAX_N   = IMG_W'(MAX_IMAGES);
    localparam logic [PIX_IDX_W-1:0] C_LAST_PIX = PIX_IDX_W'(PIXELS_PER_IMAGE - 1);
    localparam logic [GAP_W-1:0]  C_LAST_GAP = GAP_W'(GAP_CYCLES - 1);

    state_t                 r_state;
    logic [IMG_W-1:0]       r_num;
    logic [IMG_W-1:0]       r_image_index;
    logic [PIX_ADDR_W-1:0]  r_base;
    logic [PIX_ADDR_W-1:0]  r_pix_addr;
    logic [PIX_IDX_W-1:0]   r_pix_idx;
    logic                   r_pix_rd;
    logic                   r_valid_in;
    logic                   r_arm_ok;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_done;
    logic [CYC_W-1:0]       r_total;

    logic                   w_start_run;
    logic                   w_load_label;
    logic                   w_wait_active;
    logic                   w_resolve;
    logic [IMG_W-1:0]       w_num_clamped;

    assign w_start_run   = (r_state == IDLE) && start && (num_images != '0);
    assign w_load_label  = (r_state == ARM) && r_arm_ok;
    assign w_wait_active = (r_state == WAIT_RES);
    assign w_num_clamped = (num_images > C_MAX_N) ? C_MAX_N : num_images;

    assign bus.pix_addr  = r_pix_addr;
    assign bus.pix_rd    = r_pix_rd;
    assign bus.lbl_addr  = r_image_index;
    assign bus.valid_in  = r_valid_in;
    // Read data arrives with the delayed strobe, so it is gated rather than re-registered.
    assign bus.data_in   = r_valid_in ? bus.pix_rdata : 8'd0;

    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign image_index   = r_image_index;
    assign total_cycles  = r_total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_num         <= '0;
            r_image_index <= '0;
            r_base        <= '0;
            r_pix_addr    <= '0;
            r_pix_idx     <= '0;
            r_pix_rd      <= 1'b0;
            r_valid_in    <= 1'b0;
            r_arm_ok      <= 1'b0;
            r_gap_cnt     <= '0;
            r_done        <= 1'b0;
            r_total       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_valid_in <= r_pix_rd;
            if (r_state != IDLE) begin
                r_total <= r_total + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start_run) begin
                        r_num         <= w_num_clamped;
                        r_image_index <= '0;
                        r_base        <= '0;
                        r_total       <= '0;
                        r_arm_ok      <= 1'b0;
                        r_state       <= ARM;
                    end else if (start) begin
                        r_done <= 1'b1;
                    end
                end
                // First qualified cycle presents the label address, the next one captures it.
                ARM: begin
                    if (!r_arm_ok) begin
                        if (!bus.cnn_busy) begin
                            r_arm_ok <= 1'b1;
                        end
                    end else begin
                        r_arm_ok   <= 1'b0;
                        r_pix_rd   <= 1'b1;
                        r_pix_addr <= r_base;
                        r_pix_idx  <= '0;
                        r_state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (r_pix_idx == C_LAST_PIX) begin
                        r_pix_rd <= 1'b0;
                        r_state  <= WAIT_RES;
                    end else begin
                        r_pix_idx  <= r_pix_idx + 1'b1;
                        r_pix_addr <= r_pix_addr + 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (w_resolve) begin
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == C_LAST_GAP) begin
                        if (r_image_index == (r_num - 1'b1)) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_image_index <= r_image_index + 1'b1;
                            r_base        <= r_base + PIX_ADDR_W'(PIXELS_PER_IMAGE);
                            r_arm_ok      <= 1'b0;
                            r_state       <= ARM;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    cnn_result_scoreboard #(
        .IMG_W          (IMG_W),
        .RESULT_TIMEOUT (RESULT_TIMEOUT)
    ) u_scoreboard (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_clear         (w_start_run),
        .i_load_label    (w_load_label),
        .i_label         (bus.lbl_rdata),
        .i_wait_active   (w_wait_active),
        .i_valid_out     (bus.valid_out),
        .i_decision      (bus.decision),
        .o_resolve       (w_resolve),
        .o_correct_count (correct_count),
        .o_timeout_err   (timeout_err)
    );
endmodule
`default_nettype wire
